upsampler_nn: RTL and testbench
===============================

# upsampler_nn

Parametrised nearest-neighbour integer upsampler for the feature-detection video path. It accepts a FACTOR-times-decimated pixel stream over a valid/ready handshake and emits a full-resolution OUT_COLS x OUT_ROWS raster. Each input pixel is replicated FACTOR times horizontally. Each input row is replayed FACTOR times vertically from an internal line buffer. It sits between the downsampled detector stage and the display/compositing path, and supports output backpressure.

## Interface
- DATA_W, 8: pixel width in bits.
- OUT_COLS, 800: output columns; must be a multiple of FACTOR.
- OUT_ROWS, 600: output rows; must be a multiple of FACTOR.
- FACTOR, 2: scale factor; legal values are 1, 2, 4.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- in_data  in  DATA_W  decimated input pixel.
- in_valid  in  1  input beat valid.
- in_sof  in  1  input beat is the first pixel of a frame; used only with UPSAMPLER_SOF_SYNC_EN.
- in_ready  out  1  input beat consumed this cycle.
- out_data  out  DATA_W  output pixel.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_sof  out  1  out_valid at row 0, col 0.
- out_eol  out  1  out_valid at col OUT_COLS-1.
- out_row  out  clog2(OUT_ROWS)  current output row.
- out_col  out  clog2(OUT_COLS)  current output column.
- sync_err  out  1  one-cycle pulse when a frame is aborted by a mid-frame SOF.

## Operation
- Position counters: out_col and out_row. A handshake (out_valid && out_ready) advances out_col. At col OUT_COLS-1 it wraps to 0 and increments out_row. At (OUT_ROWS-1, OUT_COLS-1) both wrap to 0.
- Line buffer: OUT_COLS/FACTOR x DATA_W, with asynchronous read and synchronous write. It is not instantiated when FACTOR=1.
- Fill row (out_row % FACTOR == 0):
  - out_data = in_data.
  - out_valid = in_valid.
  - in_ready = out_ready && (out_col % FACTOR == FACTOR-1).
  - The input beat is held for FACTOR output beats and consumed on the last one.
  - On consume, the beat is written to linebuf[out_col/FACTOR].
- Repeat row (out_row % FACTOR != 0):
  - out_data = linebuf[out_col/FACTOR].
  - out_valid = 1.
  - in_ready = 0.
- FACTOR=1: the block is a pure pass-through (in_ready = out_ready), with counters, flags and sync logic still active.
- No output beat is ever dropped or duplicated under backpressure. All state holds while out_ready=0.

## Timing
- Fill rows have zero-cycle latency: in_valid, in_data and out_ready propagate combinationally to out_valid, out_data and in_ready.
- Repeat rows stream one pixel per cycle whenever out_ready=1.
- Counters, line-buffer writes and sync_err update on the rising edge.
- Reset values:
  - out_row = 0, out_col = 0, sync_err = 0, in_ready = 0 (reset-gated).
  - out_valid follows the fill-row rule, gated low during reset.
  - out_sof and out_eol = 0 while out_valid = 0.
  - Line buffer contents are don't-care; they are always written before being read.
- Reset mid-frame: counters return to (0,0) the next cycle. The partial frame is abandoned, and the next input beat is treated as pixel (0,0).
- The last fill-row write and the first repeat-row read of the same address never coincide: the row transition is always at least one cycle after the write.

## Configuration
- Macro: UPSAMPLER_SOF_SYNC_EN.
- Defined:
  - If in_valid && in_sof while (out_row, out_col) != (0,0), in either row type, then for that cycle out_valid = 0 and in_ready = 0.
  - On the next edge the counters are forced to (0,0) and sync_err pulses for one cycle.
  - The SOF beat is then emitted as pixel (0,0).
  - At (0,0), a valid beat with in_sof = 0 is discarded (in_ready = 1, out_valid = 0, no counter change).
- Undefined: in_sof is ignored, sync_err is tied to 0, and counters free-run on handshakes only.

## Test plan
- FACTOR=2, OUT_COLS=8, OUT_ROWS=4, inputs 0..7 with out_ready=1 -> rows 0 and 1 are 0,0,1,1,2,2,3,3; rows 2 and 3 are 4,4,5,5,6,6,7,7. in_ready is high on odd columns of even rows only. out_sof is high on beat 0; out_eol is high on beats 7, 15, 23 and 31.
- Same configuration with out_ready toggled 1,0,1,0 -> an identical output sequence, with no repeats or losses.
- FACTOR=4, OUT_COLS=16, OUT_ROWS=8, two back-to-back frames -> each input pixel appears as a 4x4 block, and the counters wrap to (0,0) exactly after beat 127.
- FACTOR=1 -> out_data = in_data every cycle, and in_ready equals out_ready.
- UPSAMPLER_SOF_SYNC_EN, SOF asserted at output (1,3) -> one stall cycle, sync_err = 1 for one cycle, and the next out_sof carries the SOF pixel. Non-SOF beats arriving at (0,0) are consumed with no output.
- Reset asserted at output (2,5) -> out_row = 0 and out_col = 0 on the next cycle, and the next beat is emitted with out_sof = 1.

Source files
------------

// File: rtl/upsampler_nn.sv
// upsampler_nn: nearest-neighbour FACTOR-x upsampler that replays each input row from a one-line buffer.
// Optional frame resync on in_sof is compiled in when UPSAMPLER_SOF_SYNC_EN is defined.
module upsampler_nn #(
    parameter int DATA_W   = 8,
    parameter int OUT_COLS = 800,
    parameter int OUT_ROWS = 600,
    parameter int FACTOR   = 2,
    localparam int RW = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1,
    localparam int CW = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_sof,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eol,
    output logic [RW-1:0]     out_row,
    output logic [CW-1:0]     out_col,
    output logic              sync_err
);

    logic [RW-1:0]     out_row_q, out_row_d;
    logic [CW-1:0]     out_col_q, out_col_d;
    logic              sync_err_q, sync_err_d;
    logic              fill_row, col_last, at_origin, col_wrap, row_wrap;
    logic              resync, beat, lb_we;
    logic              valid_c, ready_c;
    logic [DATA_W-1:0] data_c, lb_rdata;

    always_comb begin
        fill_row  = (int'(out_row_q) % FACTOR) == 0;
        col_last  = (int'(out_col_q) % FACTOR) == (FACTOR - 1);
        at_origin = (out_row_q == '0) && (out_col_q == '0);
        col_wrap  = out_col_q == CW'(OUT_COLS - 1);
        row_wrap  = out_row_q == RW'(OUT_ROWS - 1);
        resync    = 1'b0;
        if (fill_row) begin
            valid_c = in_valid;
            data_c  = in_data;
            ready_c = out_ready && col_last;
        end else begin
            valid_c = 1'b1;
            data_c  = lb_rdata;
            ready_c = 1'b0;
        end
`ifdef UPSAMPLER_SOF_SYNC_EN
        // The SOF beat itself stays on the input while it is replicated across row 0.
        if (in_valid && in_sof && !at_origin &&
            !((out_row_q == '0) && (int'(out_col_q) < FACTOR))) begin
            valid_c = 1'b0;
            ready_c = 1'b0;
            resync  = 1'b1;
        end else if (in_valid && !in_sof && at_origin) begin
            valid_c = 1'b0;
            ready_c = 1'b1;
        end
`endif
        if (reset) begin
            valid_c = 1'b0;
            ready_c = 1'b0;
            resync  = 1'b0;
        end

        beat  = valid_c && out_ready;
        lb_we = beat && fill_row && col_last;

        out_col_d  = out_col_q;
        out_row_d  = out_row_q;
        sync_err_d = resync;
        if (resync) begin
            out_col_d = '0;
            out_row_d = '0;
        end else if (beat) begin
            if (col_wrap) begin
                out_col_d = '0;
                out_row_d = row_wrap ? '0 : out_row_q + 1'b1;
            end else begin
                out_col_d = out_col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_row_q  <= '0;
            out_col_q  <= '0;
            sync_err_q <= 1'b0;
        end else begin
            out_row_q  <= out_row_d;
            out_col_q  <= out_col_d;
            sync_err_q <= sync_err_d;
        end
    end

    generate
        if (FACTOR > 1) begin : g_lb
            localparam int LB_DEPTH = OUT_COLS / FACTOR;
            localparam int LW = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
            logic [DATA_W-1:0] lb_mem [LB_DEPTH];
            logic [LW-1:0]     lb_idx;

            assign lb_idx   = LW'(int'(out_col_q) / FACTOR);
            assign lb_rdata = lb_mem[lb_idx];

            always_ff @(posedge clock) begin
                if (lb_we) begin
                    lb_mem[lb_idx] <= in_data;
                end
            end
        end else begin : g_nolb
            logic unused_we;
            assign unused_we = lb_we;
            assign lb_rdata  = '0;
        end
    endgenerate

`ifndef UPSAMPLER_SOF_SYNC_EN
    logic unused_sof;
    assign unused_sof = in_sof;
`endif

    assign in_ready  = ready_c;
    assign out_valid = valid_c;
    assign out_data  = data_c;
    assign out_sof   = valid_c && at_origin;
    assign out_eol   = valid_c && col_wrap;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_upsampler_nn.sv
// Directed bench for upsampler_nn: FACTOR=2 (8x4), FACTOR=4 (16x8) and FACTOR=1 (4x2) instances.
module tb_upsampler_nn;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // FACTOR=2, 8x4
    logic       a_reset, a_in_valid, a_in_sof, a_in_ready, a_out_valid, a_out_ready;
    logic       a_out_sof, a_out_eol, a_sync_err;
    logic [7:0] a_in_data, a_out_data;
    logic [1:0] a_out_row;
    logic [2:0] a_out_col;

    // FACTOR=4, 16x8
    logic       b_reset, b_in_valid, b_in_sof, b_in_ready, b_out_valid, b_out_ready;
    logic       b_out_sof, b_out_eol, b_sync_err;
    logic [7:0] b_in_data, b_out_data;
    logic [2:0] b_out_row;
    logic [3:0] b_out_col;

    // FACTOR=1, 4x2
    logic       c_reset, c_in_valid, c_in_sof, c_in_ready, c_out_valid, c_out_ready;
    logic       c_out_sof, c_out_eol, c_sync_err;
    logic [7:0] c_in_data, c_out_data;
    logic [0:0] c_out_row;
    logic [1:0] c_out_col;

    logic [7:0] exp_f2 [32] = '{
        8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3,
        8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3,
        8'd4, 8'd4, 8'd5, 8'd5, 8'd6, 8'd6, 8'd7, 8'd7,
        8'd4, 8'd4, 8'd5, 8'd5, 8'd6, 8'd6, 8'd7, 8'd7};

    upsampler_nn #(.DATA_W(8), .OUT_COLS(8), .OUT_ROWS(4), .FACTOR(2)) ua (
        .clock(clock), .reset(a_reset), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_sof(a_in_sof), .in_ready(a_in_ready), .out_data(a_out_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sof(a_out_sof),
        .out_eol(a_out_eol), .out_row(a_out_row), .out_col(a_out_col), .sync_err(a_sync_err));

    upsampler_nn #(.DATA_W(8), .OUT_COLS(16), .OUT_ROWS(8), .FACTOR(4)) ub (
        .clock(clock), .reset(b_reset), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_sof(b_in_sof), .in_ready(b_in_ready), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sof(b_out_sof),
        .out_eol(b_out_eol), .out_row(b_out_row), .out_col(b_out_col), .sync_err(b_sync_err));

    upsampler_nn #(.DATA_W(8), .OUT_COLS(4), .OUT_ROWS(2), .FACTOR(1)) uc (
        .clock(clock), .reset(c_reset), .in_data(c_in_data), .in_valid(c_in_valid),
        .in_sof(c_in_sof), .in_ready(c_in_ready), .out_data(c_out_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_sof(c_out_sof),
        .out_eol(c_out_eol), .out_row(c_out_row), .out_col(c_out_col), .sync_err(c_sync_err));

    task automatic pulse_reset_a;
        a_reset = 1'b1; a_in_valid = 1'b0; a_in_sof = 1'b0; a_out_ready = 1'b1;
        @(posedge clock); #1;
        a_reset = 1'b0;
    endtask

    task automatic test_reset;
        a_reset = 1'b1; a_in_valid = 1'b1; a_in_data = 8'h3C; a_in_sof = 1'b0; a_out_ready = 1'b1;
        b_reset = 1'b1; b_in_valid = 1'b0; b_in_data = 8'h00; b_in_sof = 1'b0; b_out_ready = 1'b1;
        c_reset = 1'b1; c_in_valid = 1'b0; c_in_data = 8'h00; c_in_sof = 1'b0; c_out_ready = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        checks++; if (a_out_row !== 2'd0 || a_out_col !== 3'd0)
            begin errors++; $display("FAIL reset_pos: row=%0d col=%0d want 0,0", a_out_row, a_out_col); end
        checks++; if (a_sync_err !== 1'b0)
            begin errors++; $display("FAIL reset_sync_err: got %b want 0", a_sync_err); end
        checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0)
            begin errors++; $display("FAIL reset_gating: out_valid=%b in_ready=%b want 0,0", a_out_valid, a_in_ready); end
        checks++; if (a_out_sof !== 1'b0 || a_out_eol !== 1'b0)
            begin errors++; $display("FAIL reset_flags: sof=%b eol=%b want 0,0", a_out_sof, a_out_eol); end
        checks++; if (b_out_row !== 3'd0 || b_out_col !== 4'd0)
            begin errors++; $display("FAIL reset_pos_b: row=%0d col=%0d want 0,0", b_out_row, b_out_col); end
        @(posedge clock); #1;
        a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0; a_in_valid = 1'b0;
    endtask

    task automatic test_upscale_f2;
        int ptr;
        logic exp_rdy;
        ptr = 0;
        for (int n = 0; n < 32; n++) begin
            a_in_valid = (ptr < 8); a_in_data = 8'(ptr); a_in_sof = (ptr == 0); a_out_ready = 1'b1;
            @(negedge clock);
            exp_rdy = ((n / 8) % 2 == 0) && ((n % 8) % 2 == 1);
            checks++; if (a_out_valid !== 1'b1 || a_out_data !== exp_f2[n])
                begin errors++; $display("FAIL f2_data beat %0d: valid=%b data=%0d want 1,%0d", n, a_out_valid, a_out_data, exp_f2[n]); end
            checks++; if (a_in_ready !== exp_rdy)
                begin errors++; $display("FAIL f2_in_ready beat %0d: got %b want %b", n, a_in_ready, exp_rdy); end
            checks++; if (a_out_sof !== (n == 0))
                begin errors++; $display("FAIL f2_sof beat %0d: got %b want %b", n, a_out_sof, (n == 0)); end
            checks++; if (a_out_eol !== (n % 8 == 7))
                begin errors++; $display("FAIL f2_eol beat %0d: got %b want %b", n, a_out_eol, (n % 8 == 7)); end
            if (a_in_valid && a_in_ready) ptr++;
            @(posedge clock); #1;
        end
        a_in_valid = 1'b0;
        @(negedge clock);
        checks++; if (ptr != 8 || a_out_row !== 2'd0 || a_out_col !== 3'd0)
            begin errors++; $display("FAIL f2_wrap: consumed=%0d row=%0d col=%0d want 8,0,0", ptr, a_out_row, a_out_col); end
        @(posedge clock); #1;
    endtask

    task automatic test_backpressure;
        int ptr, k;
        ptr = 0; k = 0;
        for (int cyc = 0; cyc < 80 && k < 32; cyc++) begin
            a_in_valid = (ptr < 8); a_in_data = 8'(ptr); a_in_sof = (ptr == 0);
            a_out_ready = (cyc % 2 == 0);
            @(negedge clock);
            checks++; if (!a_out_ready && a_in_ready)
                begin errors++; $display("FAIL bp_ready cycle %0d: in_ready=%b want 0", cyc, a_in_ready); end
            if (a_out_valid && a_out_ready) begin
                checks++; if (a_out_data !== exp_f2[k])
                    begin errors++; $display("FAIL bp_data beat %0d: got %0d want %0d", k, a_out_data, exp_f2[k]); end
                k++;
            end
            if (a_in_valid && a_in_ready) ptr++;
            @(posedge clock); #1;
        end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        @(negedge clock);
        checks++; if (k != 32 || ptr != 8)
            begin errors++; $display("FAIL bp_count: beats=%0d consumed=%0d want 32,8", k, ptr); end
        checks++; if (a_out_row !== 2'd0 || a_out_col !== 3'd0)
            begin errors++; $display("FAIL bp_wrap: row=%0d col=%0d want 0,0", a_out_row, a_out_col); end
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back;
        int ptr, r, c, expv;
        for (int f = 0; f < 2; f++) begin
            ptr = 0;
            for (int n = 0; n < 128; n++) begin
                r = n / 16; c = n % 16;
                b_in_valid = (ptr < 8); b_in_data = 8'(16 * f + ptr); b_in_sof = (ptr == 0);
                b_out_ready = 1'b1;
                @(negedge clock);
                expv = 16 * f + (r / 4) * 4 + c / 4;
                checks++; if (b_out_valid !== 1'b1 || b_out_data !== 8'(expv))
                    begin errors++; $display("FAIL f4_data frame %0d beat %0d: valid=%b data=%0d want 1,%0d", f, n, b_out_valid, b_out_data, expv); end
                checks++; if (b_out_row !== 3'(r) || b_out_col !== 4'(c))
                    begin errors++; $display("FAIL f4_pos frame %0d beat %0d: row=%0d col=%0d want %0d,%0d", f, n, b_out_row, b_out_col, r, c); end
                if (n == 127) begin
                    checks++; if (b_out_eol !== 1'b1)
                        begin errors++; $display("FAIL f4_eol frame %0d: got %b want 1", f, b_out_eol); end
                end
                if (b_in_valid && b_in_ready) ptr++;
                @(posedge clock); #1;
            end
            checks++; if (ptr != 8)
                begin errors++; $display("FAIL f4_consumed frame %0d: got %0d want 8", f, ptr); end
        end
        b_in_valid = 1'b0;
        @(negedge clock);
        checks++; if (b_out_row !== 3'd0 || b_out_col !== 4'd0)
            begin errors++; $display("FAIL f4_wrap: row=%0d col=%0d want 0,0", b_out_row, b_out_col); end
        @(posedge clock); #1;
    endtask

    task automatic test_passthrough;
        int beats;
        beats = 0;
        for (int i = 0; i < 16; i++) begin
            c_in_data = 8'(i * 37 + 5); c_in_valid = (i % 4 != 2); c_in_sof = 1'b0;
            c_out_ready = (i % 3 != 0);
            @(negedge clock);
            checks++; if (c_out_data !== c_in_data || c_out_valid !== c_in_valid)
                begin errors++; $display("FAIL f1_pass %0d: data=%0h valid=%b want %0h,%b", i, c_out_data, c_out_valid, c_in_data, c_in_valid); end
            checks++; if (c_in_ready !== c_out_ready)
                begin errors++; $display("FAIL f1_ready %0d: got %b want %b", i, c_in_ready, c_out_ready); end
            checks++; if (c_out_col !== 2'(beats % 4) || c_out_row !== 1'((beats / 4) % 2))
                begin errors++; $display("FAIL f1_pos %0d: row=%0d col=%0d want %0d,%0d", i, c_out_row, c_out_col, (beats / 4) % 2, beats % 4); end
            if (c_out_valid && c_out_ready) beats++;
            @(posedge clock); #1;
        end
        c_in_valid = 1'b0;
    endtask

    task automatic test_sof_sync;
        int ptr;
        pulse_reset_a();
        a_in_valid = 1'b1; a_in_sof = 1'b0; a_in_data = 8'h11; a_out_ready = 1'b1;
        @(negedge clock);
`ifdef UPSAMPLER_SOF_SYNC_EN
        checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0)
            begin errors++; $display("FAIL sof_discard: in_ready=%b out_valid=%b want 1,0", a_in_ready, a_out_valid); end
        @(posedge clock); #1;
        a_in_valid = 1'b0;
        @(negedge clock);
        checks++; if (a_out_row !== 2'd0 || a_out_col !== 3'd0)
            begin errors++; $display("FAIL sof_discard_pos: row=%0d col=%0d want 0,0", a_out_row, a_out_col); end
        @(posedge clock); #1;
`else
        checks++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h11)
            begin errors++; $display("FAIL nosof_origin: valid=%b data=%0h want 1,11", a_out_valid, a_out_data); end
        @(posedge clock); #1;
        pulse_reset_a();
`endif
        ptr = 0;
        for (int n = 0; n < 11; n++) begin
            a_in_valid = (ptr < 8); a_in_data = 8'(ptr); a_in_sof = (ptr == 0); a_out_ready = 1'b1;
            @(negedge clock);
            if (a_in_valid && a_in_ready) ptr++;
            @(posedge clock); #1;
        end
        a_in_valid = 1'b1; a_in_sof = 1'b1; a_in_data = 8'h55;
        @(negedge clock);
        checks++; if (a_out_row !== 2'd1 || a_out_col !== 3'd3)
            begin errors++; $display("FAIL sof_at13: row=%0d col=%0d want 1,3", a_out_row, a_out_col); end
`ifdef UPSAMPLER_SOF_SYNC_EN
        checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0)
            begin errors++; $display("FAIL sof_stall: out_valid=%b in_ready=%b want 0,0", a_out_valid, a_in_ready); end
        @(posedge clock); #1;
        @(negedge clock);
        checks++; if (a_sync_err !== 1'b1 || a_out_row !== 2'd0 || a_out_col !== 3'd0)
            begin errors++; $display("FAIL sof_resync: sync_err=%b row=%0d col=%0d want 1,0,0", a_sync_err, a_out_row, a_out_col); end
        checks++; if (a_out_sof !== 1'b1 || a_out_valid !== 1'b1 || a_out_data !== 8'h55)
            begin errors++; $display("FAIL sof_pixel: sof=%b valid=%b data=%0h want 1,1,55", a_out_sof, a_out_valid, a_out_data); end
        @(posedge clock); #1;
        @(negedge clock);
        checks++; if (a_sync_err !== 1'b0 || a_out_data !== 8'h55 || a_out_col !== 3'd1)
            begin errors++; $display("FAIL sof_pulse: sync_err=%b data=%0h col=%0d want 0,55,1", a_sync_err, a_out_data, a_out_col); end
`else
        checks++; if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0)
            begin errors++; $display("FAIL nosof_repeat: out_valid=%b in_ready=%b want 1,0", a_out_valid, a_in_ready); end
        @(posedge clock); #1;
        @(negedge clock);
        checks++; if (a_sync_err !== 1'b0 || a_out_row !== 2'd1 || a_out_col !== 3'd4)
            begin errors++; $display("FAIL nosof_ignore: sync_err=%b row=%0d col=%0d want 0,1,4", a_sync_err, a_out_row, a_out_col); end
`endif
        @(posedge clock); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic test_reset_midframe;
        int ptr;
        pulse_reset_a();
        ptr = 0;
        for (int n = 0; n < 21; n++) begin
            a_in_valid = (ptr < 8); a_in_data = 8'(ptr); a_in_sof = (ptr == 0); a_out_ready = 1'b1;
            @(negedge clock);
            if (a_in_valid && a_in_ready) ptr++;
            @(posedge clock); #1;
        end
        a_reset = 1'b1;
        @(negedge clock);
        checks++; if (a_out_row !== 2'd2 || a_out_col !== 3'd5 || a_out_valid !== 1'b0)
            begin errors++; $display("FAIL midrst_pre: row=%0d col=%0d valid=%b want 2,5,0", a_out_row, a_out_col, a_out_valid); end
        @(posedge clock); #1;
        a_reset = 1'b0; a_in_valid = 1'b1; a_in_sof = 1'b1; a_in_data = 8'hA5;
        @(negedge clock);
        checks++; if (a_out_row !== 2'd0 || a_out_col !== 3'd0)
            begin errors++; $display("FAIL midrst_pos: row=%0d col=%0d want 0,0", a_out_row, a_out_col); end
        checks++; if (a_out_sof !== 1'b1 || a_out_valid !== 1'b1 || a_out_data !== 8'hA5)
            begin errors++; $display("FAIL midrst_sof: sof=%b valid=%b data=%0h want 1,1,a5", a_out_sof, a_out_valid, a_out_data); end
        @(posedge clock); #1;
        a_in_valid = 1'b0;
    endtask

    initial begin
        @(posedge clock); #1;
        test_reset();
        test_upscale_f2();
        test_backpressure();
        test_back_to_back();
        test_passthrough();
        test_sof_sync();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
